// File: rtl/avgpool_seq_if.sv
// Signal bundle between the 2x2 average-pool sequencer and its layer controller,
// input buffer RAM, shared pool engine and output buffer RAM.
interface avgpool_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              start;
    logic              busy;
    logic              done;

    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [DATA_W-1:0] in_rd_data;

    logic              pe_start;
    logic [DATA_W-1:0] pe_tap0;
    logic [DATA_W-1:0] pe_tap1;
    logic [DATA_W-1:0] pe_tap2;
    logic [DATA_W-1:0] pe_tap3;
    logic              pe_done;
    logic [DATA_W-1:0] pe_result;

    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [DATA_W-1:0] out_wr_data;

    modport master (
        input  start, in_rd_data, pe_done, pe_result,
        output busy, done, in_rd_en, in_rd_addr,
        output pe_start, pe_tap0, pe_tap1, pe_tap2, pe_tap3,
        output out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        output start, in_rd_data, pe_done, pe_result,
        input  busy, done, in_rd_en, in_rd_addr,
        input  pe_start, pe_tap0, pe_tap1, pe_tap2, pe_tap3,
        input  out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/avgpool_seq.sv
// Walks a DEPTH x HEIGHT x WIDTH FP16 map one 2x2 window at a time: fetches four taps,
// runs the shared pool engine, and writes each average in channel-major raster order.
module avgpool_seq #(
    parameter int DEPTH  = 3,
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    avgpool_seq_if.master bus
);
    localparam int HO = HEIGHT / 2;
    localparam int WO = WIDTH / 2;

    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] PLANE_A = ADDR_W'(HEIGHT * WIDTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'(HO - 1);
    localparam logic [ADDR_W-1:0] LAST_J  = ADDR_W'(WO - 1);

    if (HEIGHT < 2 || (HEIGHT % 2) != 0) begin : g_bad_height
        $error("avgpool_seq: HEIGHT must be even and >= 2");
    end
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("avgpool_seq: WIDTH must be even and >= 2");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("avgpool_seq: DEPTH must be >= 1");
    end
    if (longint'(DEPTH) * HEIGHT * WIDTH > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("avgpool_seq: ADDR_W too narrow for DEPTH*HEIGHT*WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_PE_GO,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_e;

    state_e            state_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] c_q, i_q, j_q;
    logic [ADDR_W-1:0] c_d, i_d, j_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] in_rd_addr_q;
    logic [DATA_W-1:0] tap_q [4];
    logic [DATA_W-1:0] result_q;
    logic              busy_q, done_q, in_rd_en_q, pe_start_q, out_wr_en_q;
    logic              last_win;

    // Tap k of window (c,i,j): row 2i+k[1], column 2j+k[0] within plane c.
    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [ADDR_W-1:0] c,
        input logic [ADDR_W-1:0] i,
        input logic [ADDR_W-1:0] j,
        input logic [1:0]        k
    );
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = {i[ADDR_W-2:0], k[1]};
        col = {j[ADDR_W-2:0], k[0]};
        return c * PLANE_A + row * W_A + col;
    endfunction

    assign last_win = (c_q == LAST_C) && (i_q == LAST_I) && (j_q == LAST_J);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        c_d = c_q;
        i_d = i_q;
        j_d = j_q + ADDR_W'(1);
        if (j_q == LAST_J) begin
            j_d = '0;
            i_d = i_q + ADDR_W'(1);
            if (i_q == LAST_I) begin
                i_d = '0;
                c_d = c_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            c_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            out_addr_q   <= '0;
            in_rd_addr_q <= '0;
            for (int t = 0; t < 4; t++) tap_q[t] <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_rd_en_q   <= 1'b0;
            pe_start_q   <= 1'b0;
            out_wr_en_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        c_q          <= '0;
                        i_q          <= '0;
                        j_q          <= '0;
                        out_addr_q   <= '0;
                        k_q          <= '0;
                        in_rd_en_q   <= 1'b1;
                        in_rd_addr_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    // Read data lags the address by one cycle, so this cycle's word belongs to tap k-1.
                    if (k_q != 2'd0) tap_q[k_q - 2'd1] <= bus.in_rd_data;
                    if (k_q == 2'd3) begin
                        in_rd_en_q <= 1'b0;
                        state_q    <= S_FLUSH;
                    end else begin
                        k_q          <= k_q + 2'd1;
                        in_rd_addr_q <= tap_addr(c_q, i_q, j_q, k_q + 2'd1);
                    end
                end
                S_FLUSH: begin
                    tap_q[3]   <= bus.in_rd_data;
                    pe_start_q <= 1'b1;
                    state_q    <= S_PE_GO;
                end
                S_PE_GO: begin
                    pe_start_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.pe_done) begin
                        result_q    <= bus.pe_result;
                        out_wr_en_q <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    out_wr_en_q <= 1'b0;
                    if (last_win) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        c_q          <= c_d;
                        i_q          <= i_d;
                        j_q          <= j_d;
                        out_addr_q   <= out_addr_q + ADDR_W'(1);
                        k_q          <= '0;
                        in_rd_en_q   <= 1'b1;
                        in_rd_addr_q <= tap_addr(c_d, i_d, j_d, 2'd0);
                        state_q      <= S_READ;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.in_rd_en    = in_rd_en_q;
    assign bus.in_rd_addr  = in_rd_addr_q;
    assign bus.pe_start    = pe_start_q;
    assign bus.pe_tap0     = tap_q[0];
    assign bus.pe_tap1     = tap_q[1];
    assign bus.pe_tap2     = tap_q[2];
    assign bus.pe_tap3     = tap_q[3];
    assign bus.out_wr_en   = out_wr_en_q;
    assign bus.out_wr_addr = out_addr_q;
    assign bus.out_wr_data = result_q;
endmodule

// File: tb/tb_avgpool_seq.sv
// Scoreboard bench for avgpool_seq: a 3x4x4 instance and a 1x2x2 instance, each with a
// behavioural input RAM and an FP16 averaging pool engine of programmable latency.
module tb_avgpool_seq;
    localparam int DW = 16;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    avgpool_seq_if #(.DATA_W(DW), .ADDR_W(AW)) m_if ();
    avgpool_seq_if #(.DATA_W(DW), .ADDR_W(AW)) s_if ();

    avgpool_seq #(.DEPTH(3), .HEIGHT(4), .WIDTH(4), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.master)
    );

    avgpool_seq #(.DEPTH(1), .HEIGHT(2), .WIDTH(2), .DATA_W(DW), .ADDR_W(AW)) dut_min (
        .clk (clk),
        .rst (rst),
        .bus (s_if.master)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- FP16 helpers for the behavioural pool engine ----------------
    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) begin
            v = real'(h[9:0]);
            e = -24;
        end else begin
            v = real'(int'(h[9:0]) + 1024);
            e = int'(h[14:10]) - 25;
        end
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        if (h[15]) v = -v;
        return v;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        int e;
        int m;
        if (v <= 0.0) return 16'h0000;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = int'((v - 1.0) * 1024.0);
        if (m == 1024) begin m = 0; e++; end
        return {1'b0, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] avg4(input logic [15:0] a, b, c, d);
        return r2h((h2r(a) + h2r(b) + h2r(c) + h2r(d)) / 4.0);
    endfunction

    // Every channel holds 1.0 .. 16.0 in FP16.
    logic [DW-1:0] val_tbl [16];
    logic [DW-1:0] win_res [4];
    initial begin
        val_tbl = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
                    16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
        win_res = '{16'h4300, 16'h4580, 16'h49C0, 16'h4AC0};
    end

    // ---------------- environment models ----------------
    always @(posedge clk) if (m_if.in_rd_en) m_if.in_rd_data <= val_tbl[m_if.in_rd_addr[3:0]];
    always @(posedge clk) if (s_if.in_rd_en) s_if.in_rd_data <= val_tbl[s_if.in_rd_addr[3:0]];

    int   pe_lat = 3;
    int   m_rem  = 0;
    logic m_act  = 1'b0;
    always @(posedge clk) begin
        m_if.pe_done <= 1'b0;
        if (m_if.pe_start) begin
            m_if.pe_result <= avg4(m_if.pe_tap0, m_if.pe_tap1, m_if.pe_tap2, m_if.pe_tap3);
            m_rem <= pe_lat - 1;
            m_act <= (pe_lat > 1);
            if (pe_lat == 1) m_if.pe_done <= 1'b1;
        end else if (m_act) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_if.pe_done <= 1'b1;
                m_act        <= 1'b0;
            end
        end
    end

    int   s_rem = 0;
    logic s_act = 1'b0;
    always @(posedge clk) begin
        s_if.pe_done <= 1'b0;
        if (s_if.pe_start) begin
            s_if.pe_result <= avg4(s_if.pe_tap0, s_if.pe_tap1, s_if.pe_tap2, s_if.pe_tap3);
            s_rem <= 2;
            s_act <= 1'b1;
        end else if (s_act) begin
            s_rem <= s_rem - 1;
            if (s_rem == 1) begin
                s_if.pe_done <= 1'b1;
                s_act        <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard: main instance ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr_q [$];
    logic [AW-1:0] exp_rd_q [$];
    logic [63:0]   exp_tap_q [$];

    int            wr_cnt = 0, done_cnt = 0, pe_cnt = 0, rd_cnt = 0;
    int            done_rel = 0, start_cyc = 0, pe_base = 0, rd_base = 0;
    int            pe_cyc0 = 0, pe_cyc1 = 0;
    logic [63:0]   tap_w6 = '0;
    logic [AW-1:0] rd_log [4];

    always @(negedge clk) begin
        if (m_if.in_rd_en) begin
            check("rd_expected", exp_rd_q.size() > 0, 1);
            if (exp_rd_q.size() > 0) check("rd_addr", m_if.in_rd_addr, exp_rd_q.pop_front());
            if (rd_cnt - rd_base >= 24 && rd_cnt - rd_base < 28) rd_log[rd_cnt - rd_base - 24] = m_if.in_rd_addr;
            rd_cnt++;
        end
        if (m_if.pe_start) begin
            check("tap_expected", exp_tap_q.size() > 0, 1);
            if (exp_tap_q.size() > 0)
                check("pe_taps", {m_if.pe_tap0, m_if.pe_tap1, m_if.pe_tap2, m_if.pe_tap3}, exp_tap_q.pop_front());
            if (pe_cnt - pe_base == 0) pe_cyc0 = cyc;
            if (pe_cnt - pe_base == 1) pe_cyc1 = cyc;
            if (pe_cnt - pe_base == 6) tap_w6 = {m_if.pe_tap0, m_if.pe_tap1, m_if.pe_tap2, m_if.pe_tap3};
            pe_cnt++;
        end
        if (m_if.out_wr_en) begin
            check("wr_expected", exp_wr_q.size() > 0, 1);
            if (exp_wr_q.size() > 0) begin
                wr_t w;
                w = exp_wr_q.pop_front();
                check("wr_addr", m_if.out_wr_addr, w.addr);
                check("wr_data", m_if.out_wr_data, w.data);
            end
            wr_cnt++;
        end
        if (m_if.done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
        end
    end

    // ---------------- scoreboard: minimal instance ----------------
    wr_t           s_wr_q [$];
    logic [AW-1:0] s_rd_q [$];
    int            s_wr_cnt = 0, s_done_cnt = 0, s_done_rel = 0, s_start_cyc = 0;

    always @(negedge clk) begin
        if (s_if.in_rd_en) begin
            check("min_rd_expected", s_rd_q.size() > 0, 1);
            if (s_rd_q.size() > 0) check("min_rd_addr", s_if.in_rd_addr, s_rd_q.pop_front());
        end
        if (s_if.out_wr_en) begin
            check("min_wr_expected", s_wr_q.size() > 0, 1);
            if (s_wr_q.size() > 0) begin
                wr_t w;
                w = s_wr_q.pop_front();
                check("min_wr_addr", s_if.out_wr_addr, w.addr);
                check("min_wr_data", s_if.out_wr_data, w.data);
            end
            s_wr_cnt++;
        end
        if (s_if.done) begin
            s_done_cnt++;
            s_done_rel = cyc - s_start_cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_main_pass();
        int            a;
        int            w;
        logic [DW-1:0] tp [4];
        w = 0;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    for (int k = 0; k < 4; k++) begin
                        a = c * 16 + (2 * i + k / 2) * 4 + 2 * j + k % 2;
                        exp_rd_q.push_back(AW'(a));
                        tp[k] = val_tbl[a % 16];
                    end
                    exp_tap_q.push_back({tp[0], tp[1], tp[2], tp[3]});
                    exp_wr_q.push_back('{addr: AW'(w), data: win_res[i * 2 + j]});
                    w++;
                end
    endtask

    task automatic run_pass(input int lat, input bit poke);
        int w0, d0, t_end, t_done;
        pe_lat = lat;
        push_main_pass();
        @(negedge clk);
        w0        = wr_cnt;
        d0        = done_cnt;
        pe_base   = pe_cnt;
        rd_base   = rd_cnt;
        start_cyc = cyc;
        m_if.start = 1'b1;
        t_done = 12 * (7 + lat) + 1;
        t_end  = t_done + 25;
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            // Extra start pulses land in WAIT of window 0 and on the FIN cycle.
            m_if.start = poke && (t == 8 || t == t_done);
        end
        m_if.start = 1'b0;
        check("done_cycle", done_rel, t_done);
        check("done_pulses", done_cnt - d0, 1);
        check("write_count", wr_cnt - w0, 12);
        check("window_period", pe_cyc1 - pe_cyc0, 7 + lat);
        check("writes_left", exp_wr_q.size(), 0);
        check("w6_taps", tap_w6, {16'h4880, 16'h4900, 16'h4A80, 16'h4B00});
        check("w6_reads", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, {12'd24, 12'd25, 12'd28, 12'd29});
    endtask

    task automatic run_reset_mid();
        int w0, w_start;
        pe_lat = 3;
        push_main_pass();
        @(negedge clk);
        w_start   = wr_cnt;
        pe_base   = pe_cnt;
        rd_base   = rd_cnt;
        start_cyc = cyc;
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int t = 0; t < 200 && (pe_cnt - pe_base) < 6; t++) @(negedge clk);
        check("reach_window5", pe_cnt - pe_base, 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        check("writes_before_rst", w0 - w_start, 5);
        check("rst_busy", m_if.busy, 0);
        check("rst_done", m_if.done, 0);
        check("rst_rd_en", m_if.in_rd_en, 0);
        check("rst_pe_start", m_if.pe_start, 0);
        check("rst_wr_en", m_if.out_wr_en, 0);
        check("rst_rd_addr", m_if.in_rd_addr, 0);
        check("rst_wr_addr", m_if.out_wr_addr, 0);
        check("rst_wr_data", m_if.out_wr_data, 0);
        check("rst_taps", {m_if.pe_tap0, m_if.pe_tap1, m_if.pe_tap2, m_if.pe_tap3}, 0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_tap_q.delete();
        repeat (20) @(negedge clk);
        check("no_write_after_rst", wr_cnt - w0, 0);
    endtask

    task automatic run_min();
        int w0, d0;
        for (int a = 0; a < 4; a++) s_rd_q.push_back(AW'(a));
        s_wr_q.push_back('{addr: AW'(0), data: 16'h4100});
        @(negedge clk);
        w0          = s_wr_cnt;
        d0          = s_done_cnt;
        s_start_cyc = cyc;
        s_if.start  = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        repeat (30) @(negedge clk);
        check("min_done_cycle", s_done_rel, 11);
        check("min_done_pulses", s_done_cnt - d0, 1);
        check("min_write_count", s_wr_cnt - w0, 1);
        check("min_reads_left", s_rd_q.size(), 0);
    endtask

    initial begin
        m_if.start = 1'b0;
        s_if.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", m_if.busy, 0);
        check("reset_done", m_if.done, 0);
        check("reset_rd_en", m_if.in_rd_en, 0);
        check("reset_pe_start", m_if.pe_start, 0);
        check("reset_wr_en", m_if.out_wr_en, 0);
        check("reset_min_busy", s_if.busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_pass(3, 1'b1);
        run_pass(1, 1'b0);
        run_pass(7, 1'b0);
        run_reset_mid();
        run_pass(3, 1'b0);
        run_min();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
